// File: rtl/video_out_hmag_core_if.sv
// Signal bundle for video_out_hmag_core: VDP pixel write side, output raster counter,
// scaling registers and the scaled colour outputs.
interface video_out_hmag_core_if;
   logic        enable;
   logic [10:0] vdp_hcounter;
   logic [1:0]  vdp_vcounter;
   logic [10:0] h_cnt;
   logic [5:0]  vdp_r;
   logic [5:0]  vdp_g;
   logic [5:0]  vdp_b;
   logic [7:0]  reg_left_offset;
   logic [7:0]  reg_denominator;
   logic [7:0]  reg_normalize;
   logic        reg_scanline;
   logic [7:0]  video_r;
   logic [7:0]  video_g;
   logic [7:0]  video_b;

   modport master (
      output enable, vdp_hcounter, vdp_vcounter, h_cnt, vdp_r, vdp_g, vdp_b,
             reg_left_offset, reg_denominator, reg_normalize, reg_scanline,
      input  video_r, video_g, video_b
   );

   modport slave (
      input  enable, vdp_hcounter, vdp_vcounter, h_cnt, vdp_r, vdp_g, vdp_b,
             reg_left_offset, reg_denominator, reg_normalize, reg_scanline,
      output video_r, video_g, video_b
   );
endinterface

// File: rtl/video_out_hmag_core.sv
// Horizontal magnifier: double-banked line buffer resampled onto the output raster with
// linear interpolation. Scanline dimming is built only when VIDEO_OUT_HMAG_SCANLINE_EN is defined.
module video_out_hmag_core #(
   parameter int H_OUT_START = 100,
   parameter int H_OUT_WIDTH = 1200
) (
   input logic                  clk,
   input logic                  reset_n,
   video_out_hmag_core_if.slave bus
);
   localparam int          LINE_DEPTH = 684;
   localparam logic [9:0]  PTR_MAX    = 10'd683;
   localparam logic [10:0] START_CNT  = 11'(H_OUT_START);
   localparam int          WIN_END    = H_OUT_START + H_OUT_WIDTH;

   logic [17:0] mem_q [2][LINE_DEPTH];

   logic [9:0] wr_addr;
   assign wr_addr = bus.vdp_hcounter[10:1];

   always_ff @(posedge clk) begin
      if (bus.enable && bus.vdp_hcounter[0] && (int'(wr_addr) < LINE_DEPTH))
         mem_q[bus.vdp_vcounter[1]][wr_addr] <= {bus.vdp_r, bus.vdp_g, bus.vdp_b};
   end

   logic line_start;
   logic in_win;
   assign line_start = (bus.h_cnt == START_CNT);
   assign in_win     = (int'(bus.h_cnt) >= H_OUT_START) && (int'(bus.h_cnt) < WIN_END);

   logic [9:0] ptr_q, ptr_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] den_q, den_d;
   logic [7:0] norm_q, norm_d;
   logic [8:0] phase_sum;
   logic       val0_q, val0_d;
   logic       dim0_q, dim0_d;

   // Scale registers are captured at line start so mid-line writes wait for the next line.
   always_comb begin
      ptr_d     = ptr_q;
      phase_d   = phase_q;
      den_d     = den_q;
      norm_d    = norm_q;
      phase_sum = {1'b0, phase_q} + 9'd128;
      if (line_start) begin
         ptr_d   = {2'b00, bus.reg_left_offset};
         phase_d = '0;
         den_d   = bus.reg_denominator;
         norm_d  = bus.reg_normalize;
      end else if (in_win) begin
         if (phase_sum >= {1'b0, den_q}) begin
            phase_d = 8'(phase_sum - {1'b0, den_q});
            if (ptr_q != PTR_MAX)
               ptr_d = ptr_q + 10'd1;
         end else begin
            phase_d = phase_sum[7:0];
         end
      end
   end

   // Output stays dark after a mid-line reset until a proper line start is seen.
   assign val0_d = in_win && (line_start || val0_q);

`ifdef VIDEO_OUT_HMAG_SCANLINE_EN
   logic scan_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         scan_q <= 1'b0;
      else if (line_start)
         scan_q <= bus.reg_scanline;
   end

   assign dim0_d = (line_start ? bus.reg_scanline : scan_q) && bus.vdp_vcounter[0];
`else
   // Dimming not built: the scanline inputs are tied off here.
   assign dim0_d = 1'b0 && (bus.reg_scanline || bus.vdp_vcounter[0]);
`endif

   logic [9:0] ptr_b;
   logic [8:0] w_raw;
   logic [7:0] w_d;
   logic       rd_bank;
   assign ptr_b   = (ptr_q == PTR_MAX) ? PTR_MAX : ptr_q + 10'd1;
   assign w_raw   = 9'((16'(phase_q) * 16'(norm_q)) >> 7);
   assign w_d     = w_raw[8] ? 8'hFF : w_raw[7:0];
   assign rd_bank = ~bus.vdp_vcounter[1];

   logic [17:0] a_q, b_q;
   logic [7:0]  w_q;
   logic        val1_q, dim1_q;
   logic [7:0]  video_r_q, video_g_q, video_b_q;

   function automatic logic [7:0] blend(input logic [5:0] a, input logic [5:0] b,
                                        input logic [7:0] w);
      logic [13:0] s;
      s = 14'(a) * 14'(9'd256 - {1'b0, w}) + 14'(b) * 14'(w);
      return 8'(s >> 6);
   endfunction

   function automatic logic [7:0] dimmed(input logic [7:0] v, input logic en);
      return en ? v - (v >> 2) : v;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q     <= '0;
         phase_q   <= '0;
         den_q     <= '0;
         norm_q    <= '0;
         val0_q    <= 1'b0;
         dim0_q    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         w_q       <= '0;
         val1_q    <= 1'b0;
         dim1_q    <= 1'b0;
         video_r_q <= '0;
         video_g_q <= '0;
         video_b_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         phase_q <= phase_d;
         den_q   <= den_d;
         norm_q  <= norm_d;
         val0_q  <= val0_d;
         dim0_q  <= dim0_d;

         // Reads hit the bank opposite the one being written, so both ports run freely.
         a_q    <= mem_q[rd_bank][ptr_q];
         b_q    <= mem_q[rd_bank][ptr_b];
         w_q    <= w_d;
         val1_q <= val0_q;
         dim1_q <= dim0_q;

         video_r_q <= val1_q ? dimmed(blend(a_q[17:12], b_q[17:12], w_q), dim1_q) : 8'h00;
         video_g_q <= val1_q ? dimmed(blend(a_q[11:6],  b_q[11:6],  w_q), dim1_q) : 8'h00;
         video_b_q <= val1_q ? dimmed(blend(a_q[5:0],   b_q[5:0],   w_q), dim1_q) : 8'h00;
      end
   end

   assign bus.video_r = video_r_q;
   assign bus.video_g = video_g_q;
   assign bus.video_b = video_b_q;
endmodule

// File: tb/tb_video_out_hmag_core.sv
// Directed bench for video_out_hmag_core: per-line expectations from a behavioural resampler
// plus fixed reference values, checked through a 3-deep latency scoreboard.
module tb_video_out_hmag_core;
   localparam int START = 100;
   localparam int W     = 1200;
`ifdef VIDEO_OUT_HMAG_SCANLINE_EN
   localparam bit DIM_ON = 1'b1;
`else
   localparam bit DIM_ON = 1'b0;
`endif

   logic clk;
   logic reset_n;

   video_out_hmag_core_if bus();

   video_out_hmag_core #(.H_OUT_START(START), .H_OUT_WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      logic [23:0] exp_v;
      int          id;
      int          h;
   } sb_t;

   sb_t         sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cur_id  = 0;
   string       names [9];
   logic [17:0] src [2][684];
   logic [23:0] exp_line [W];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input bit chk, input logic [23:0] exp_v);
      sb_t         e;
      logic [23:0] obs;
      sb_q.push_back('{chk: chk, exp_v: exp_v, id: cur_id, h: int'(bus.h_cnt)});
      @(posedge clk);
      #1;
      if (sb_q.size() >= 3) begin
         e = sb_q.pop_front();
         if (e.chk) begin
            obs = {bus.video_r, bus.video_g, bus.video_b};
            n_tests++;
            assert (obs === e.exp_v)
               else begin
                  n_fail++;
                  $error("FAIL %s h_cnt=%0d observed=%h expected=%h", names[e.id], e.h, obs, e.exp_v);
               end
         end
      end
   endtask

   task automatic fill(input int bank, input int kind, input int off);
      logic [17:0] d;
      bus.vdp_vcounter = {1'(bank), 1'b0};
      bus.h_cnt        = 11'd0;
      bus.enable       = 1'b1;
      for (int i = 0; i < 684; i++) begin
         d = (kind == 0) ? 18'h3FFFF : 18'($urandom);
         if (kind == 1 && i == off) d = {3{6'd63}};
         if (kind == 1 && (i == off + 1 || i == off + 2)) d = {3{6'd1}};
         bus.vdp_hcounter = 11'(2 * i + 1);
         {bus.vdp_r, bus.vdp_g, bus.vdp_b} = d;
         src[bank][i] = d;
         tick(1'b1, 24'h0);
      end
      // Neither of these cycles may write: even hcounter, then enable low.
      bus.vdp_hcounter = 11'd2;
      {bus.vdp_r, bus.vdp_g, bus.vdp_b} = 18'h0;
      tick(1'b1, 24'h0);
      bus.enable       = 1'b0;
      bus.vdp_hcounter = 11'd5;
      tick(1'b1, 24'h0);
   endtask

   task automatic build_model(input int rb, input int off, input int den, input int norm,
                              input bit dim);
      int ptr, ph, w, pb, ac, bc, v;
      logic [17:0] a, b;
      ptr = off;
      ph  = 0;
      for (int k = 0; k < W; k++) begin
         if (k > 0) begin
            ph += 128;
            if (ph >= den) begin
               ph -= den;
               if (ptr < 683) ptr++;
            end
         end
         w = (ph * norm) / 128;
         if (w > 255) w = 255;
         pb = (ptr < 683) ? ptr + 1 : 683;
         a  = src[rb][ptr];
         b  = src[rb][pb];
         for (int c = 0; c < 3; c++) begin
            ac = int'(a >> (12 - 6 * c)) & 63;
            bc = int'(b >> (12 - 6 * c)) & 63;
            v  = (ac * (256 - w) + bc * w) / 64;
            if (dim) v = v - v / 4;
            exp_line[k][23 - 8 * c -: 8] = 8'(v);
         end
      end
   endtask

   task automatic play_line(input bit vc1, input bit odd, input int off, input int den,
                            input int norm, input bit scan, input bit wr, input bit mid);
      logic [17:0] d;
      bus.vdp_vcounter    = {vc1, odd};
      bus.reg_left_offset = 8'(off);
      bus.reg_denominator = 8'(den);
      bus.reg_normalize   = 8'(norm);
      bus.reg_scanline    = scan;
      bus.enable          = wr;
      for (int h = START - 4; h < START + W + 4; h++) begin
         bus.h_cnt = 11'(h);
         if (mid && h == START + 10) begin
            bus.reg_denominator = 8'd200;
            bus.reg_normalize   = 8'd163;
            bus.reg_left_offset = 8'd0;
            bus.reg_scanline    = ~scan;
         end
         if (wr) begin
            d = 18'($urandom);
            bus.vdp_hcounter = 11'(h);
            {bus.vdp_r, bus.vdp_g, bus.vdp_b} = d;
            if ((h % 2) == 1 && (h / 2) < 684) src[vc1][h / 2] = d;
         end
         tick(1'b1, (h >= START && h < START + W) ? exp_line[h - START] : 24'h0);
      end
      bus.enable = 1'b0;
   endtask

   initial begin
      logic [23:0] obs;
      logic [17:0] last;
      names = '{"reset_midline", "fill_idle", "flat_white", "scanline", "interp",
                "mid_reg_change", "den200_wr_other", "after_write", "clamp"};
      reset_n              = 1'b0;
      bus.enable           = 1'b0;
      bus.vdp_hcounter     = 11'd0;
      bus.vdp_vcounter     = 2'd0;
      bus.h_cnt            = 11'd0;
      {bus.vdp_r, bus.vdp_g, bus.vdp_b} = 18'h0;
      bus.reg_left_offset  = 8'd0;
      bus.reg_denominator  = 8'd160;
      bus.reg_normalize    = 8'd204;
      bus.reg_scanline     = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      obs = {bus.video_r, bus.video_g, bus.video_b};
      n_tests++;
      assert (obs === 24'h0)
         else begin
            n_fail++;
            $error("FAIL reset_hold observed=%h expected=%h", obs, 24'h0);
         end

      // Release mid-window: nothing may appear before the next line start.
      cur_id    = 0;
      bus.h_cnt = 11'(START + 50);
      reset_n   = 1'b1;
      for (int h = START + 50; h < START + W + 4; h++) begin
         bus.h_cnt = 11'(h);
         tick(1'b1, 24'h0);
      end

      cur_id = 1;
      fill(0, 0, 0);
      fill(1, 1, 20);

      cur_id = 2;
      for (int k = 0; k < W; k++) exp_line[k] = {3{8'hFC}};
      play_line(1'b1, 1'b0, 0, 160, 204, 1'b1, 1'b0, 1'b0);

      cur_id = 3;
      for (int k = 0; k < W; k++) exp_line[k] = DIM_ON ? {3{8'hBD}} : {3{8'hFC}};
      play_line(1'b1, 1'b1, 0, 160, 204, 1'b1, 1'b0, 1'b0);

      cur_id = 4;
      build_model(1, 20, 160, 204, 1'b0);
      exp_line[0] = {3{8'hFC}};
      exp_line[1] = {3{8'h36}};
      exp_line[2] = {3{8'h04}};
      play_line(1'b0, 1'b0, 20, 160, 204, 1'b0, 1'b0, 1'b0);

      cur_id = 5;
      build_model(1, 37, 144, 227, 1'b0);
      play_line(1'b0, 1'b1, 37, 144, 227, 1'b0, 1'b0, 1'b1);

      cur_id = 6;
      build_model(1, 5, 200, 163, DIM_ON);
      play_line(1'b0, 1'b1, 5, 200, 163, 1'b1, 1'b1, 1'b0);

      cur_id = 7;
      build_model(0, 50, 180, 182, 1'b0);
      play_line(1'b1, 1'b0, 50, 180, 182, 1'b0, 1'b0, 1'b0);

      cur_id = 8;
      build_model(1, 112, 160, 204, 1'b0);
      last = src[1][683];
      exp_line[W - 1] = {last[17:12], 2'b00, last[11:6], 2'b00, last[5:0], 2'b00};
      play_line(1'b0, 1'b0, 112, 160, 204, 1'b0, 1'b0, 1'b0);

      repeat (3) tick(1'b0, 24'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
